// File: rtl/factorial_ctrl.sv
// rtl/factorial_ctrl.sv - N! sequencer driving a 64x64->128 multiplier as a slave
//
// Computes acc = 1; for k = 2..n: acc = acc[63:0] * k, one multiplier job per step.
// Every output is a register; the multiplier operand buses are taken straight
// from the k and acc registers so they stay stable for the whole job.
//
// Ports:
//   clk              in   clock, all state on rising edge
//   reset            in   synchronous active-high reset
//   op_start         in   start N! of n (accepted only in IDLE)
//   op_clear         in   abort/clear from any state, wins over op_start
//   n                in   operand, captured when op_start is accepted
//   op_done          out  high in DONE
//   busy             out  high in ISSUE, WAIT, RELEASE
//   result           out  accumulator, valid while op_done, zero otherwise
//   overflow         out  sticky: a product with nonzero [127:64] was fed back truncated
//   error            out  sticky: multiplier did not answer within TIMEOUT cycles
//   mul_start        out  multiplier op_start
//   mul_clear        out  multiplier op_clear (held high whenever no job is in flight)
//   mul_multiplier   out  zero-extended k
//   mul_multiplicand out  acc[63:0]
//   mul_done         in   multiplier op_done
//   mul_result       in   multiplier 128-bit product

module factorial_ctrl #(
    parameter int N_WIDTH = 8,
    parameter int TIMEOUT = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic [N_WIDTH-1:0] n,
    output logic               op_done,
    output logic               busy,
    output logic [127:0]       result,
    output logic               overflow,
    output logic               error,
    output logic               mul_start,
    output logic               mul_clear,
    output logic [63:0]        mul_multiplier,
    output logic [63:0]        mul_multiplicand,
    input  logic               mul_done,
    input  logic [127:0]       mul_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [127:0]       acc, acc_nx;
    logic [N_WIDTH-1:0] k, k_nx;
    logic [N_WIDTH-1:0] n_q, n_nx;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
    logic               overflow_nx, error_nx;
    logic               op_done_nx, busy_nx, mul_start_nx, mul_clear_nx;
    logic [127:0]       result_nx;

    assign mul_multiplier   = {{(64-N_WIDTH){1'b0}}, k};
    assign mul_multiplicand = acc[63:0];

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        k_nx        = k;
        n_nx        = n_q;
        wait_cnt_nx = wait_cnt;
        overflow_nx = overflow;
        error_nx    = error;

        if (op_clear) begin
            // Abort: any job in flight is dropped; mul_clear goes high below.
            state_nx    = S_IDLE;
            acc_nx      = 128'd1;
            k_nx        = '0;
            wait_cnt_nx = '0;
            overflow_nx = 1'b0;
            error_nx    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_start) begin
                        n_nx        = n;
                        acc_nx      = 128'd1;
                        k_nx        = N_WIDTH'(2);
                        wait_cnt_nx = '0;
                        overflow_nx = 1'b0;
                        error_nx    = 1'b0;
                        state_nx    = (n < N_WIDTH'(2)) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_nx = '0;
                    state_nx    = S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        acc_nx = mul_result;
                        // Only a product that feeds another step loses its upper half.
                        if ((mul_result[127:64] != 64'd0) && (k < n_q))
                            overflow_nx = 1'b1;
                        state_nx = S_RELEASE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        error_nx = 1'b1;
                        state_nx = S_RELEASE;
                    end else begin
                        wait_cnt_nx = wait_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if ((k == n_q) || error) begin
                        state_nx = S_DONE;
                    end else begin
                        k_nx     = k + N_WIDTH'(1);
                        state_nx = S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_nx = S_DONE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end

        // Outputs are registered, so they are decoded from the next state.
        busy_nx      = (state_nx == S_ISSUE) || (state_nx == S_WAIT) || (state_nx == S_RELEASE);
        mul_start_nx = (state_nx == S_ISSUE);
        mul_clear_nx = !((state_nx == S_ISSUE) || (state_nx == S_WAIT));
        op_done_nx   = (state_nx == S_DONE);
        result_nx    = (state_nx == S_DONE) ? acc_nx : 128'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            acc       <= 128'd1;
            k         <= '0;
            n_q       <= '0;
            wait_cnt  <= '0;
            overflow  <= 1'b0;
            error     <= 1'b0;
            op_done   <= 1'b0;
            busy      <= 1'b0;
            result    <= 128'd0;
            mul_start <= 1'b0;
            mul_clear <= 1'b1;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            k         <= k_nx;
            n_q       <= n_nx;
            wait_cnt  <= wait_cnt_nx;
            overflow  <= overflow_nx;
            error     <= error_nx;
            op_done   <= op_done_nx;
            busy      <= busy_nx;
            result    <= result_nx;
            mul_start <= mul_start_nx;
            mul_clear <= mul_clear_nx;
        end
    end

endmodule
